// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the ping-pong match-state logic.
package score_keeper_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StServeWait,
    StServeReq,
    StRally,
    StGameOver
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic SIDE_P1 = 1'b0;
  localparam logic SIDE_P2 = 1'b1;

  // A one-cycle delay still needs a 1-bit counter.
  function automatic int unsigned timer_width(input int unsigned delay);
    return (delay <= 1) ? 1 : $clog2(delay);
  endfunction

endpackage

// File: rtl/score_keeper_serve_timer.sv
// Loadable down-counter pacing the gap between a point and the next serve request.
module serve_timer
  import score_keeper_pkg::*;
#(
  parameter int unsigned SERVE_DELAY = 100
) (
  input  logic sys_clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = timer_width(SERVE_DELAY);
  localparam logic [CntW-1:0] LoadVal = CntW'(SERVE_DELAY - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LoadVal;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/score_keeper.sv
// Match-state producer: scores, winner and serve handshake for the ping-pong game.
// Optional build macro WIN_BY_TWO_EN enables win-by-two with deuce folding.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned SERVE_DELAY = 100
) (
  input  logic               sys_clock,
  input  logic               reset,
  input  logic               start,
  input  logic               reset_game,
  input  logic               point_p1,
  input  logic               point_p2,
  input  logic               serve_ack,
  output logic [SCORE_W-1:0] sc1,
  output logic [SCORE_W-1:0] sc2,
  output logic               serve_req,
  output logic               serve_side,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] sc1_q, sc1_d, sc2_q, sc2_d;
  logic               serve_req_q, serve_req_d;
  logic               serve_side_q, serve_side_d;
  logic               game_over_q, game_over_d;
  logic [1:0]         winner_q, winner_d;

  logic               timer_load, timer_en, timer_expired;
  logic [SCORE_W-1:0] new_sc1, new_sc2;
  logic               p1_wins, p2_wins;

  serve_timer #(
    .SERVE_DELAY(SERVE_DELAY)
  ) u_serve_timer (
    .sys_clock(sys_clock),
    .reset    (reset),
    .load     (timer_load),
    .enable   (timer_en),
    .expired  (timer_expired)
  );

  // Candidate scores and win decision for a single-point rally.
  always_comb begin
    new_sc1 = sc1_q + SCORE_W'(point_p1);
    new_sc2 = sc2_q + SCORE_W'(point_p2);
`ifdef WIN_BY_TWO_EN
    p1_wins = (new_sc1 >= WinScore) &&
              ({1'b0, new_sc1} >= ({1'b0, new_sc2} + (SCORE_W + 1)'(2)));
    p2_wins = (new_sc2 >= WinScore) &&
              ({1'b0, new_sc2} >= ({1'b0, new_sc1} + (SCORE_W + 1)'(2)));
    if ((new_sc1 == WinScore) && (new_sc2 == WinScore)) begin
      new_sc1 = WinScore - 1'b1;
      new_sc2 = WinScore - 1'b1;
    end
`else
    p1_wins = (new_sc1 == WinScore);
    p2_wins = (new_sc2 == WinScore);
`endif
  end

  always_comb begin
    state_d      = state_q;
    sc1_d        = sc1_q;
    sc2_d        = sc2_q;
    serve_req_d  = serve_req_q;
    serve_side_d = serve_side_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    timer_load   = 1'b0;
    timer_en     = 1'b0;

    if (reset_game) begin
      state_d      = StIdle;
      sc1_d        = '0;
      sc2_d        = '0;
      serve_req_d  = 1'b0;
      serve_side_d = SIDE_P1;
      game_over_d  = 1'b0;
      winner_d     = WIN_NONE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StServeWait;
            timer_load = 1'b1;
            sc1_d      = '0;
            sc2_d      = '0;
          end
        end
        StServeWait: begin
          timer_en = 1'b1;
          if (timer_expired) begin
            state_d     = StServeReq;
            serve_req_d = 1'b1;
          end
        end
        StServeReq: begin
          if (serve_ack) begin
            state_d     = StRally;
            serve_req_d = 1'b0;
          end
        end
        StRally: begin
          if (point_p1 && point_p2) begin
            // Let: replay the serve without touching score or side.
            state_d    = StServeWait;
            timer_load = 1'b1;
          end else if (point_p1 || point_p2) begin
            sc1_d        = new_sc1;
            sc2_d        = new_sc2;
            serve_side_d = point_p1 ? SIDE_P2 : SIDE_P1;
            if (p1_wins || p2_wins) begin
              state_d     = StGameOver;
              game_over_d = 1'b1;
              winner_d    = p1_wins ? WIN_P1 : WIN_P2;
            end else begin
              state_d    = StServeWait;
              timer_load = 1'b1;
            end
          end
        end
        StGameOver: begin
          state_d = StGameOver;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sc1_q        <= '0;
      sc2_q        <= '0;
      serve_req_q  <= 1'b0;
      serve_side_q <= SIDE_P1;
      game_over_q  <= 1'b0;
      winner_q     <= WIN_NONE;
    end else begin
      state_q      <= state_d;
      sc1_q        <= sc1_d;
      sc2_q        <= sc2_d;
      serve_req_q  <= serve_req_d;
      serve_side_q <= serve_side_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign sc1        = sc1_q;
  assign sc2        = sc2_q;
  assign serve_req  = serve_req_q;
  assign serve_side = serve_side_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed scoreboard bench for score_keeper (default build or WIN_BY_TWO_EN).
module tb_score_keeper;

  localparam int unsigned SD     = 4;
  localparam int          BUDGET = 40;

  logic       sys_clock;
  logic       reset;
  logic       start, reset_game, point_p1, point_p2, serve_ack;
  logic [3:0] sc1, sc2;
  logic       serve_req, serve_side, game_over;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [12:0] exp;
  } exp_t;
  exp_t sb[$];

  logic [12:0] snap;
  assign snap = {sc1, sc2, serve_req, serve_side, game_over, winner};

  score_keeper #(
    .WIN_SCORE  (7),
    .SCORE_W    (4),
    .SERVE_DELAY(SD)
  ) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .start     (start),
    .reset_game(reset_game),
    .point_p1  (point_p1),
    .point_p2  (point_p2),
    .serve_ack (serve_ack),
    .sc1       (sc1),
    .sc2       (sc2),
    .serve_req (serve_req),
    .serve_side(serve_side),
    .game_over (game_over),
    .winner    (winner)
  );

  initial begin
    sys_clock = 1'b0;
    forever #5 sys_clock = ~sys_clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] s1, input logic [3:0] s2,
                          input logic req, input logic side, input logic go,
                          input logic [1:0] win);
    exp_t e;
    e.tag = tag;
    e.exp = {s1, s2, req, side, go, win};
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      assert (snap === e.exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, snap, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count edges from the last state-changing edge until serve_req rises.
  task automatic wait_req(input string tag);
    int cnt;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((serve_req !== 1'b1) && (cnt < BUDGET));
    chk({tag, "_latency"}, cnt, SD);
  endtask

  task automatic serve(input string tag);
    wait_req(tag);
    serve_ack = 1'b1;
    tick();
    serve_ack = 1'b0;
    chk({tag, "_req_drop"}, int'(serve_req), 0);
  endtask

  task automatic point(input logic p1, input logic p2, input string tag,
                       input logic [3:0] s1, input logic [3:0] s2, input logic side,
                       input logic go, input logic [1:0] win);
    point_p1 = p1;
    point_p2 = p2;
    push_exp(tag, s1, s2, 1'b0, side, go, win);
    tick();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    pop_cmp();
  endtask

  task automatic begin_match(input string tag);
    start = 1'b1;
    push_exp({tag, "_start"}, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    start = 1'b0;
    pop_cmp();
    serve(tag);
  endtask

  initial begin
    int held;
    reset      = 1'b1;
    start      = 1'b0;
    reset_game = 1'b0;
    point_p1   = 1'b0;
    point_p2   = 1'b0;
    serve_ack  = 1'b0;
    #1 reset = 1'b0;
    #2;
    push_exp("reset_init", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    pop_cmp();
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Async reset in the middle of a rally with sc1 = 3.
    begin_match("m1");
    for (int k = 1; k <= 3; k++) begin
      point(1'b1, 1'b0, "m1_p1", 4'(k), 4'd0, 1'b1, 1'b0, 2'b00);
      serve("m1_serve");
    end
    #2 reset = 1'b0;
    #1;
    push_exp("async_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    pop_cmp();
    tick();
    reset = 1'b1;
    tick();

    // Withheld serve_ack; a point pulse during the wait is dropped.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_req("m2_first");
    held = 0;
    for (int i = 0; i < 50; i++) begin
      point_p1 = (i == 20);
      tick();
      if (serve_req === 1'b1) held++;
    end
    point_p1 = 1'b0;
    chk("ack_withheld_req_held", held, 50);
    push_exp("ack_withheld_state", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
    pop_cmp();
    serve_ack = 1'b1;
    tick();
    serve_ack = 1'b0;
    chk("late_ack_req_drop", int'(serve_req), 0);

    // Let: both pulses together.
    point(1'b1, 1'b1, "let", 4'd0, 4'd0, 1'b0, 1'b0, 2'b00);
    serve("let_serve");

    // Seven straight points for player 1.
    for (int k = 1; k <= 7; k++) begin
      point(1'b1, 1'b0, "m2_p1", 4'(k), 4'd0, 1'b1, k == 7, (k == 7) ? 2'b01 : 2'b00);
      if (k < 7) serve("m2_serve");
    end
    point(1'b1, 1'b0, "post_win_p1", 4'd7, 4'd0, 1'b1, 1'b1, 2'b01);
    point(1'b0, 1'b1, "post_win_p2", 4'd7, 4'd0, 1'b1, 1'b1, 2'b01);
    for (int i = 0; i < int'(SD) + 2; i++) tick();
    push_exp("game_over_frozen", 4'd7, 4'd0, 1'b0, 1'b1, 1'b1, 2'b01);
    pop_cmp();
    reset_game = 1'b1;
    push_exp("reset_game_clear", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    reset_game = 1'b0;
    pop_cmp();

    // reset_game beats a simultaneous point at sc2 = 6.
    begin_match("m3");
    for (int k = 1; k <= 6; k++) begin
      point(1'b0, 1'b1, "m3_p2", 4'd0, 4'(k), 1'b0, 1'b0, 2'b00);
      serve("m3_serve");
    end
    reset_game = 1'b1;
    point_p2   = 1'b1;
    push_exp("reset_game_vs_point", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    point_p2 = 1'b0;
    pop_cmp();
    start = 1'b1;
    push_exp("start_during_reset_game", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    start      = 1'b0;
    reset_game = 1'b0;
    pop_cmp();
    for (int i = 0; i < int'(SD) + 2; i++) tick();
    push_exp("still_idle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    pop_cmp();

    // Reach 6-6, then the endgame for the configured rule.
    begin_match("m4");
    for (int k = 1; k <= 6; k++) begin
      point(1'b1, 1'b0, "m4_p1", 4'(k), 4'd0, 1'b1, 1'b0, 2'b00);
      serve("m4_serve");
    end
    for (int k = 1; k <= 6; k++) begin
      point(1'b0, 1'b1, "m4_p2", 4'd6, 4'(k), 1'b0, 1'b0, 2'b00);
      serve("m4_serve");
    end
`ifdef WIN_BY_TWO_EN
    point(1'b1, 1'b0, "w2_adv_p1", 4'd7, 4'd6, 1'b1, 1'b0, 2'b00);
    serve("w2_serve");
    point(1'b0, 1'b1, "w2_deuce_fold", 4'd6, 4'd6, 1'b0, 1'b0, 2'b00);
    serve("w2_serve");
    point(1'b0, 1'b1, "w2_adv_p2", 4'd6, 4'd7, 1'b0, 1'b0, 2'b00);
    serve("w2_serve");
    point(1'b0, 1'b1, "w2_win_p2", 4'd6, 4'd8, 1'b0, 1'b1, 2'b10);
`else
    point(1'b0, 1'b1, "m4_win_p2", 4'd6, 4'd7, 1'b0, 1'b1, 2'b10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
